histogram_pingpong: RTL and testbench

Parametrised grey-level histogram engine in the `cam_clk` domain, successor to the single-RAM frame histogram. Two banks alternate roles: one accumulates the current frame while the other holds the previous frame's finished histogram for readout. Counts are exact for back-to-back identical pixels and saturate at full scale. Also provides automatic bank clearing, a frame-done strobe, a total pixel count and an overrun flag. It sits between the grey-conversion stage and the histogram display/equalisation logic.

---
 rtl/histogram_pkg.sv | 14 +
 rtl/histogram_bank_ram.sv | 20 ++
 rtl/histogram_pingpong.sv | 113 +++++++++++
 tb/tb_histogram_pingpong.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_pkg.sv
// histogram_pkg: shared state encoding and arithmetic helpers for the ping-pong histogram
package histogram_pkg;
    typedef enum logic [2:0] {INIT, IDLE, ACCUM, FLUSH, CLEAR} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

    function automatic logic [31:0] bin_of(input logic [31:0] pixel, input int pix_w, input int bin_bits);
        return pixel >> (pix_w - bin_bits);
    endfunction
endpackage

// File: rtl/histogram_bank_ram.sv
// histogram_bank_ram: one histogram bank, simple dual-port with registered read
module histogram_bank_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 19
) (
    input  logic              cam_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port plus registered read; a same-address read returns the old word
    always_ff @(posedge cam_clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/histogram_pingpong.sv
// histogram_pingpong: two-bank grey-level histogram, one bank accumulating while the other is read out
module histogram_pingpong
    import histogram_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 19
) (
    input  logic                cam_clk,
    input  logic                rst_n,
    input  logic                cam_vsync,
    input  logic                cam_valid,
    input  logic [PIX_W-1:0]    cam_gray,
    input  logic                rd_en,
    input  logic [BIN_BITS-1:0] rd_addr,
    output logic [CNT_W-1:0]    rd_data,
    output logic                rd_valid,
    output logic                frame_done,
    output logic [CNT_W-1:0]    total_pix,
    output logic                overrun,
    output logic                ready
);
    state_t              state;
    logic                acc_bank, vs_d, vs_dd, p_valid, p_fwd, rd_bank;
    logic                acc_pix, clearing, rise, fall;
    logic [BIN_BITS-1:0] clr_addr, pix_bin, p_bin;
    logic [CNT_W-1:0]    p_fwd_val, pix_cnt, cur_cnt, w_data;
    logic [CNT_W-1:0]    q [2];

    assign pix_bin  = BIN_BITS'(bin_of(32'(cam_gray), PIX_W, BIN_BITS));
    assign acc_pix  = state == ACCUM && cam_valid;
    assign clearing = state == INIT || state == CLEAR;
    assign rise     = vs_d && !vs_dd;
    assign fall     = vs_dd && !vs_d;
    // The RAM missed the write retired in the read cycle, so take that value from the bypass
    assign cur_cnt  = p_fwd ? p_fwd_val : q[acc_bank];
    assign w_data   = CNT_W'(sat_inc(32'(cur_cnt), CNT_W));
    assign rd_data  = rd_valid ? q[rd_bank] : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_acc;
        assign is_acc = acc_bank == (b != 0);
        histogram_bank_ram #(.ADDR_W(BIN_BITS), .DATA_W(CNT_W)) u_ram (
            .cam_clk (cam_clk),
            .we      (state == INIT || (is_acc && (state == CLEAR || p_valid))),
            .waddr   (clearing ? clr_addr : p_bin),
            .wdata   (clearing ? '0 : w_data),
            .raddr   (is_acc ? pix_bin : rd_addr),
            .rdata   (q[b])
        );
    end

    // Control FSM: bank zeroing, frame boundaries, bank swap and status outputs
    always_ff @(posedge cam_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            clr_addr   <= '0;
            acc_bank   <= 1'b0;
            pix_cnt    <= '0;
            total_pix  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            ready      <= 1'b0;
        end else begin
            case (state)
                INIT, CLEAR: begin
                    clr_addr <= clr_addr + BIN_BITS'(1);
                    if (&clr_addr) state <= IDLE;
                end
                IDLE: if (rise) begin
                    state   <= ACCUM;
                    pix_cnt <= '0;
                end
                ACCUM: begin
                    if (cam_valid) pix_cnt <= CNT_W'(sat_inc(32'(pix_cnt), CNT_W));
                    if (fall) state <= FLUSH;
                end
                FLUSH: begin
                    state     <= CLEAR;
                    acc_bank  <= !acc_bank;
                    total_pix <= pix_cnt;
                end
                default: state <= INIT;
            endcase
            frame_done <= state == FLUSH;
            ready      <= state == IDLE || state == ACCUM;
            overrun    <= state == FLUSH ? 1'b0 : overrun || (clearing && cam_valid);
        end
    end

    // Accumulate pipeline, vsync edge registers and readout tracking
    always_ff @(posedge cam_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d      <= 1'b0;
            vs_dd     <= 1'b0;
            p_valid   <= 1'b0;
            p_bin     <= '0;
            p_fwd     <= 1'b0;
            p_fwd_val <= '0;
            rd_valid  <= 1'b0;
            rd_bank   <= 1'b0;
        end else begin
            vs_d      <= cam_vsync;
            vs_dd     <= vs_d;
            p_valid   <= acc_pix;
            p_bin     <= pix_bin;
            p_fwd     <= acc_pix && p_valid && p_bin == pix_bin;
            p_fwd_val <= w_data;
            rd_valid  <= rd_en;
            rd_bank   <= !acc_bank;
        end
    end
endmodule

// File: tb/tb_histogram_pingpong.sv
// tb_histogram_pingpong: scoreboard bench for the ping-pong histogram (19-bit and 4-bit counter builds)
module tb_histogram_pingpong;
    localparam int NB = 256;

    typedef struct {
        int bin;
        int e;
    } exp_t;

    logic        cam_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  cam_gray = '0;
    logic [7:0]  rd_addr = '0;
    logic [18:0] rd_data, total_pix;
    logic        rd_valid, frame_done, overrun, ready;
    logic [3:0]  rd_data4, total_pix4;
    logic        rd_valid4, frame_done4, overrun4, ready4;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        sb_x;

    always #5 cam_clk = ~cam_clk;

    histogram_pingpong #(.PIX_W(8), .BIN_BITS(8), .CNT_W(19)) dut (
        .cam_clk    (cam_clk),
        .rst_n      (rst_n),
        .cam_vsync  (cam_vsync),
        .cam_valid  (cam_valid),
        .cam_gray   (cam_gray),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_done (frame_done),
        .total_pix  (total_pix),
        .overrun    (overrun),
        .ready      (ready)
    );

    histogram_pingpong #(.PIX_W(8), .BIN_BITS(8), .CNT_W(4)) dut4 (
        .cam_clk    (cam_clk),
        .rst_n      (rst_n),
        .cam_vsync  (cam_vsync),
        .cam_valid  (cam_valid),
        .cam_gray   (cam_gray),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data4),
        .rd_valid   (rd_valid4),
        .frame_done (frame_done4),
        .total_pix  (total_pix4),
        .overrun    (overrun4),
        .ready      (ready4)
    );

    // Scoreboard: every readout response is matched against the oldest queued expectation
    always @(negedge cam_clk) begin
        if (rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rd_valid_unexpected got=1 exp=0");
            end else begin
                sb_x = sb.pop_front();
                if (rd_data !== 19'(sb_x.e)) begin
                    failures++;
                    $display("FAIL rd_data bin=%0d got=%0d exp=%0d", sb_x.bin, rd_data, sb_x.e);
                end
                checks++;
                if (rd_valid4 !== 1'b1 || rd_data4 !== 4'(sb_x.e > 15 ? 15 : sb_x.e)) begin
                    failures++;
                    $display("FAIL rd_data4 bin=%0d got=%0d valid=%b exp=%0d", sb_x.bin, rd_data4, rd_valid4,
                             sb_x.e > 15 ? 15 : sb_x.e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic readout(input string tag, input int base, input int hot, input int hot_val);
        exp_t t;
        for (int a = 0; a < NB; a++) begin
            @(negedge cam_clk);
            rd_en = 1'b1;
            rd_addr = 8'(a);
            t.bin = a;
            t.e = (a == hot) ? hot_val : base;
            sb.push_back(t);
        end
        @(negedge cam_clk);
        rd_en = 1'b0;
        repeat (3) @(negedge cam_clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d pending exp=0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic send_frame(input string tag, input int n, input bit ramp, input int val,
                              input int exp_total, input bit no_wait);
        int   lat;
        logic prev_ready;
        @(negedge cam_clk);
        cam_vsync = 1'b1;
        repeat (3) @(negedge cam_clk);
        for (int i = 0; i < n; i++) begin
            cam_valid = 1'b1;
            cam_gray = ramp ? 8'(i) : 8'(val);
            @(negedge cam_clk);
            if (ramp && i % 3 == 2) begin
                cam_valid = 1'b0;
                @(negedge cam_clk);
            end
        end
        cam_valid = 1'b0;
        repeat (2) @(negedge cam_clk);
        cam_vsync = 1'b0;
        lat = 0;
        prev_ready = ready;
        while (frame_done !== 1'b1 && lat < 20) begin
            prev_ready = ready;
            @(negedge cam_clk);
            lat++;
        end
        checks++;
        if (frame_done !== 1'b1 || lat != 3) begin
            failures++;
            $display("FAIL %s_frame_done_latency got=%0d exp=3", tag, lat);
        end
        checks++;
        if (prev_ready !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_drop got=%b%b exp=10", tag, prev_ready, ready);
        end
        checks++;
        if (total_pix !== 19'(exp_total)) begin
            failures++;
            $display("FAIL %s_total_pix got=%0d exp=%0d", tag, total_pix, exp_total);
        end
        checks++;
        if (total_pix4 !== 4'(exp_total > 15 ? 15 : exp_total)) begin
            failures++;
            $display("FAIL %s_total_pix4 got=%0d exp=%0d", tag, total_pix4, exp_total > 15 ? 15 : exp_total);
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL %s_overrun_at_done got=%b exp=0", tag, overrun);
        end
        @(negedge cam_clk);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_frame_done_width got=%b exp=0", tag, frame_done);
        end
        if (!no_wait) begin
            lat = 0;
            while (ready !== 1'b1 && lat < 400) begin
                @(negedge cam_clk);
                lat++;
            end
            checks++;
            if (ready !== 1'b1) begin
                failures++;
                $display("FAIL %s_clear_end got=%b exp=1", tag, ready);
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        repeat (3) @(negedge cam_clk);
        checks++;
        if ({ready, rd_valid, frame_done, overrun} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {ready, rd_valid, frame_done, overrun});
        end
        checks++;
        if (total_pix !== '0 || rd_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%0d/%0d exp=0/0", total_pix, rd_data);
        end
        rst_n = 1'b1;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 400) begin
            @(negedge cam_clk);
            cyc++;
        end
        checks++;
        if (ready !== 1'b1 || cyc < 256 || cyc > 258) begin
            failures++;
            $display("FAIL init_ready_cycles got=%0d exp=256..258", cyc);
        end
        cam_gray = 8'h99;
        cam_valid = 1'b1;
        repeat (3) @(negedge cam_clk);
        cam_valid = 1'b0;
        @(negedge cam_clk);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL idle_pixels_overrun got=%b exp=0", overrun);
        end
        readout("init", 0, -1, 0);
    endtask

    task automatic test_single_bin();
        send_frame("b2b", 1000, 1'b0, 'h37, 1000, 1'b0);
        readout("b2b", 0, 'h37, 1000);
    endtask

    task automatic test_ramp();
        send_frame("ramp", 1024, 1'b1, 0, 1024, 1'b0);
        readout("ramp", 4, -1, 0);
        send_frame("ff", 300, 1'b0, 'hff, 300, 1'b0);
        readout("ff", 0, 255, 300);
    endtask

    task automatic test_saturation();
        send_frame("sat", 20, 1'b0, 'h10, 20, 1'b0);
        readout("sat", 0, 'h10, 20);
    endtask

    task automatic test_overrun_skip();
        int w;
        send_frame("ovr_a", 9, 1'b0, 'h44, 9, 1'b1);
        cam_vsync = 1'b1;
        cam_gray = 8'h44;
        cam_valid = 1'b1;
        repeat (5) @(negedge cam_clk);
        cam_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL clear_overrun_set got=%b exp=1", overrun);
        end
        w = 0;
        while (ready !== 1'b1 && w < 400) begin
            @(negedge cam_clk);
            w++;
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL ovr_clear_end got=%b exp=1", ready);
        end
        repeat (5) @(negedge cam_clk);
        cam_vsync = 1'b0;
        w = 0;
        repeat (12) begin
            @(negedge cam_clk);
            if (frame_done === 1'b1) w++;
        end
        checks++;
        if (w != 0) begin
            failures++;
            $display("FAIL skipped_frame_done got=%0d exp=0", w);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got=%b exp=1", overrun);
        end
        readout("ovr_a", 0, 'h44, 9);
        send_frame("ovr_b", 7, 1'b0, 'h22, 7, 1'b0);
        readout("ovr_b", 0, 'h22, 7);
    endtask

    task automatic test_reset_mid();
        exp_t t;
        int   cyc;
        @(negedge cam_clk);
        cam_vsync = 1'b1;
        repeat (3) @(negedge cam_clk);
        for (int i = 0; i < 10; i++) begin
            cam_valid = 1'b1;
            cam_gray = 8'h55;
            rd_en = 1'b1;
            rd_addr = 8'h22;
            t.bin = 'h22;
            t.e = 7;
            sb.push_back(t);
            @(negedge cam_clk);
        end
        checks++;
        if (rd_valid !== 1'b1 || total_pix !== 19'd7) begin
            failures++;
            $display("FAIL pre_reset_state got=%b/%0d exp=1/7", rd_valid, total_pix);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL async_reset_rd got=%b/%0d exp=0/0", rd_valid, rd_data);
        end
        checks++;
        if (total_pix !== '0 || total_pix4 !== '0) begin
            failures++;
            $display("FAIL async_reset_total got=%0d/%0d exp=0/0", total_pix, total_pix4);
        end
        checks++;
        if ({ready, frame_done, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_flags got=%b exp=000", {ready, frame_done, overrun});
        end
        sb.delete();
        rd_en = 1'b0;
        cam_valid = 1'b0;
        cam_vsync = 1'b0;
        repeat (3) @(negedge cam_clk);
        rst_n = 1'b1;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 400) begin
            @(negedge cam_clk);
            cyc++;
        end
        checks++;
        if (ready !== 1'b1 || total_pix !== '0) begin
            failures++;
            $display("FAIL reinit got=%b/%0d exp=1/0", ready, total_pix);
        end
        readout("rst_mid", 0, -1, 0);
    endtask

    initial begin
        test_reset();
        test_single_bin();
        test_ramp();
        test_saturation();
        test_overrun_skip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
